lcd_text_buf: RTL and testbench

Character frame buffer feeding the text-LCD controller. Holds the 2×16 display image as 32 ASCII bytes. Accepts single-character writes and binary-number writes from application logic; number writes are converted sequentially to four decimal ASCII digits. The LCD controller reads the image through a registered read port and uses a dirty flag to decide when to redraw.

---
 rtl/lcd_text_buf_if.sv | 41 ++++
 rtl/lcd_text_buf.sv | 176 +++++++++++++++++
 tb/tb_lcd_text_buf.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_buf_if.sv
// ============================================================================
//  Module      : lcd_text_buf_if
//  Description : Bus bundle between application logic / LCD controller and
//                the lcd_text_buf character frame buffer.
//                Write side : wr_valid, wr_ready, wr_mode, wr_addr, wr_char,
//                             wr_num, wr_zblank
//                Read side  : rd_addr, rd_data, dirty, refresh_done
//                master = requester/controller side, slave = frame buffer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lcd_text_buf_if #(
    parameter int NUM_W = 14
);
    logic             wr_valid;
    logic             wr_ready;
    logic             wr_mode;
    logic [4:0]       wr_addr;
    logic [7:0]       wr_char;
    logic [NUM_W-1:0] wr_num;
    logic             wr_zblank;
    logic [4:0]       rd_addr;
    logic [7:0]       rd_data;
    logic             dirty;
    logic             refresh_done;

    modport master (
        output wr_valid, wr_mode, wr_addr, wr_char, wr_num, wr_zblank,
        output rd_addr, refresh_done,
        input  wr_ready, rd_data, dirty
    );

    modport slave (
        input  wr_valid, wr_mode, wr_addr, wr_char, wr_num, wr_zblank,
        input  rd_addr, refresh_done,
        output wr_ready, rd_data, dirty
    );
endinterface

`default_nettype wire

// File: rtl/lcd_text_buf.sv
// ============================================================================
//  Module      : lcd_text_buf
//  Description : 2x16 text-LCD frame buffer (32 ASCII cells). Accepts
//                character writes and binary number writes; numbers are
//                saturated to 9999 and converted by double-dabble into four
//                ASCII digits written to consecutive (wrapping) cells.
//                Registered read port and a dirty flag for the controller.
//  Ports       : clk  - system clock (posedge)
//                rst  - asynchronous reset, active low
//                bus  - lcd_text_buf_if.slave (write request / read port)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_text_buf #(
    parameter int         NUM_W = 14,
    parameter logic [7:0] FILL  = 8'h20
) (
    input  logic           clk,
    input  logic           rst,
    lcd_text_buf_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam int               C_CNT_W   = $clog2(NUM_W + 1);
    localparam logic [NUM_W-1:0] C_NUM_MAX = NUM_W'(9999);

    state_t             r_state;
    logic               r_wr_ready;
    logic [4:0]         r_addr;
    logic               r_zblank;
    logic               r_blank;     // still inside the run of leading zeros
    logic [NUM_W-1:0]   r_shift;
    logic [15:0]        r_bcd;
    logic [C_CNT_W-1:0] r_cnt;
    logic [1:0]         r_digit;
    logic [7:0]         r_buf [0:31];
    logic [7:0]         r_rd_data;
    logic               r_dirty;

    logic               w_accept;
    logic [NUM_W-1:0]   w_sat;
    logic [15:0]        w_bcd_adj;
    logic [3:0]         w_nib;
    logic               w_blank_now;
    logic               w_we;
    logic [4:0]         w_waddr;
    logic [7:0]         w_wdata;

    assign w_accept = bus.wr_valid && r_wr_ready;
    assign w_sat    = (bus.wr_num > C_NUM_MAX) ? C_NUM_MAX : bus.wr_num;

    // Double-dabble correction applied before every shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    // Digit 0 is thousands (top nibble), digit 3 is ones
    always_comb begin
        case (r_digit)
            2'd0:    w_nib = r_bcd[15:12];
            2'd1:    w_nib = r_bcd[11:8];
            2'd2:    w_nib = r_bcd[7:4];
            default: w_nib = r_bcd[3:0];
        endcase
    end

    assign w_blank_now = r_blank && (w_nib == 4'd0) && (r_digit != 2'd3);

    // Single buffer write port shared by character writes and digit writes
    always_comb begin
        w_we    = 1'b0;
        w_waddr = bus.wr_addr;
        w_wdata = bus.wr_char;
        if (r_state == ST_IDLE && w_accept && !bus.wr_mode) begin
            w_we = 1'b1;
        end else if (r_state == ST_WRITE) begin
            w_we    = 1'b1;
            w_waddr = r_addr + {3'b000, r_digit};   // 5-bit add wraps 31 -> 0
            w_wdata = w_blank_now ? FILL : (8'h30 + {4'h0, w_nib});
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_wr_ready <= 1'b1;
            r_addr     <= '0;
            r_zblank   <= 1'b0;
            r_blank    <= 1'b0;
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_digit    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && bus.wr_mode) begin
                        r_addr     <= bus.wr_addr;
                        r_zblank   <= bus.wr_zblank;
                        r_shift    <= w_sat;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_wr_ready <= 1'b0;
                        r_state    <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    {r_bcd, r_shift} <= {w_bcd_adj, r_shift} << 1;
                    r_cnt <= r_cnt + C_CNT_W'(1);
                    if (r_cnt == C_CNT_W'(NUM_W - 1)) begin
                        r_digit <= 2'd0;
                        r_blank <= r_zblank;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_digit <= r_digit + 2'd1;
                    if (!w_blank_now)
                        r_blank <= 1'b0;
                    if (r_digit == 2'd3) begin
                        r_wr_ready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_wr_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++)
                r_buf[i] <= FILL;
        end else if (w_we) begin
            r_buf[w_waddr] <= w_wdata;
        end
    end

    // Non-blocking read: a same-cycle write to the same cell shows old data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_rd_data <= FILL;
        else
            r_rd_data <= r_buf[bus.rd_addr];
    end

    // A write wins over a coincident refresh_done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_dirty <= 1'b1;
        else if (w_we)
            r_dirty <= 1'b1;
        else if (bus.refresh_done)
            r_dirty <= 1'b0;
    end

    assign bus.wr_ready = r_wr_ready;
    assign bus.rd_data  = r_rd_data;
    assign bus.dirty    = r_dirty;

endmodule

`default_nettype wire

// File: tb/tb_lcd_text_buf.sv
// ============================================================================
//  Module      : tb_lcd_text_buf
//  Description : Self-checking bench for lcd_text_buf. Keeps a 32-cell
//                reference image; expected read bytes are queued when a read
//                is issued and popped when rd_data is produced.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lcd_text_buf;

    localparam int NUM_W = 14;

    logic clk;
    logic rst;

    lcd_text_buf_if #(.NUM_W(NUM_W)) bus ();

    lcd_text_buf #(.NUM_W(NUM_W), .FILL(8'h20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] mdl [32];
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Expected four ASCII bytes {thousands, hundreds, tens, ones}
    function automatic logic [31:0] num_chars(input int num, input bit zb);
        int         n;
        int         v [4];
        bit         lead;
        logic [31:0] r;
        n    = (num > 9999) ? 9999 : num;
        v[0] = n / 1000;
        v[1] = (n / 100) % 10;
        v[2] = (n / 10) % 10;
        v[3] = n % 10;
        lead = zb;
        r    = '0;
        for (int k = 0; k < 4; k++) begin
            if (lead && v[k] == 0 && k < 3) begin
                r[8*(3-k) +: 8] = 8'h20;
            end else begin
                r[8*(3-k) +: 8] = 8'(8'h30 + v[k]);
                lead = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input string tag, input int a, input logic [7:0] e);
        exp_q.push_back(e);
        bus.rd_addr = 5'(a);
        tick();
        check(tag, {24'h0, bus.rd_data}, {24'h0, exp_q.pop_front()});
    endtask

    task automatic dump(input string tag);
        for (int a = 0; a < 32; a++)
            rd_check(tag, a, mdl[a]);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!bus.wr_ready && t < 50) begin
            tick();
            t++;
        end
        check("wait_rdy", {31'h0, bus.wr_ready}, 32'd1);
    endtask

    task automatic pulse_refresh();
        bus.refresh_done = 1'b1;
        tick();
        bus.refresh_done = 1'b0;
    endtask

    task automatic wr_char_t(input int a, input logic [7:0] ch);
        wait_ready();
        bus.wr_valid = 1'b1;
        bus.wr_mode  = 1'b0;
        bus.wr_addr  = 5'(a);
        bus.wr_char  = ch;
        tick();
        bus.wr_valid = 1'b0;
        mdl[a] = ch;
    endtask

    // rf_at: edge offset after acceptance at which refresh_done is high (0 = none)
    task automatic wr_num_t(input int a, input int num, input bit zb, input int rf_at);
        int          cnt;
        logic [31:0] c;
        wait_ready();
        bus.wr_valid  = 1'b1;
        bus.wr_mode   = 1'b1;
        bus.wr_addr   = 5'(a);
        bus.wr_num    = NUM_W'(num);
        bus.wr_zblank = zb;
        tick();
        bus.wr_valid = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            if (bus.wr_ready) break;
            cnt++;
            bus.refresh_done = (i == rf_at);
            tick();
        end
        bus.refresh_done = 1'b0;
        check("rdy_lo_cycles", 32'(cnt), 32'd18);
        c = num_chars(num, zb);
        for (int k = 0; k < 4; k++)
            mdl[(a + k) % 32] = c[8*(3-k) +: 8];
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_ready", {31'h0, bus.wr_ready}, 32'd1);
        check("rst_dirty", {31'h0, bus.dirty}, 32'd1);
        check("rst_rddata", {24'h0, bus.rd_data}, 32'h20);
        for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        bit acc;
        logic [31:0] c;
        rst              = 1'b1;
        bus.wr_valid     = 1'b0;
        bus.wr_mode      = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_char      = '0;
        bus.wr_num       = '0;
        bus.wr_zblank    = 1'b0;
        bus.rd_addr      = '0;
        bus.refresh_done = 1'b0;

        do_reset();
        tick();
        dump("reset_img");
        check("rst_dirty_post", {31'h0, bus.dirty}, 32'd1);

        // Refresh clears dirty, then character write with readback
        pulse_refresh();
        check("dirty_clr", {31'h0, bus.dirty}, 32'd0);
        bus.rd_addr = 5'd5;
        wr_char_t(5, 8'h41);
        check("rd_old_same_edge", {24'h0, bus.rd_data}, 32'h20);
        tick();
        check("rd_new", {24'h0, bus.rd_data}, 32'h41);
        check("dirty_char", {31'h0, bus.dirty}, 32'd1);

        // Number writes
        wr_num_t(16, 1234, 1'b0, 0);
        dump("num_1234");
        wr_num_t(30, 7, 1'b1, 0);
        dump("num_7_wrap");
        wr_num_t(8, 0, 1'b1, 0);
        dump("num_0_zb");
        wr_num_t(10, 12000, 1'b0, 0);
        dump("num_sat");
        wr_num_t(20, 9999, 1'b0, 0);
        dump("num_9999");
        wr_num_t(24, 0, 1'b0, 0);
        dump("num_0000");
        wr_num_t(26, 405, 1'b1, 0);
        dump("num_405_zb");

        // refresh_done coinciding with a digit write leaves dirty set
        pulse_refresh();
        check("dirty_clr2", {31'h0, bus.dirty}, 32'd0);
        wr_num_t(12, 88, 1'b0, 16);
        check("dirty_coincide", {31'h0, bus.dirty}, 32'd1);
        pulse_refresh();
        check("dirty_clr3", {31'h0, bus.dirty}, 32'd0);
        dump("num_88");

        // Reset in the middle of a conversion aborts the write
        wait_ready();
        bus.wr_valid  = 1'b1;
        bus.wr_mode   = 1'b1;
        bus.wr_addr   = 5'd0;
        bus.wr_num    = NUM_W'(4321);
        bus.wr_zblank = 1'b0;
        tick();
        bus.wr_valid = 1'b0;
        check("conv_busy", {31'h0, bus.wr_ready}, 32'd0);
        repeat (4) tick();
        do_reset();
        repeat (20) tick();
        check("abort_ready", {31'h0, bus.wr_ready}, 32'd1);
        check("abort_dirty", {31'h0, bus.dirty}, 32'd1);
        dump("abort_img");

        // Request held during a conversion is accepted only back in IDLE
        wait_ready();
        bus.wr_valid  = 1'b1;
        bus.wr_mode   = 1'b1;
        bus.wr_addr   = 5'd2;
        bus.wr_num    = NUM_W'(56);
        bus.wr_zblank = 1'b0;
        tick();
        bus.wr_mode = 1'b0;
        bus.wr_addr = 5'd3;
        bus.wr_char = 8'h5A;
        cnt = 0;
        acc = 1'b0;
        while (!acc && cnt < 40) begin
            acc = bus.wr_ready;
            tick();
            cnt++;
        end
        bus.wr_valid = 1'b0;
        check("held_accept_edge", 32'(cnt), 32'd19);
        c = num_chars(56, 1'b0);
        for (int k = 0; k < 4; k++)
            mdl[(2 + k) % 32] = c[8*(3-k) +: 8];
        mdl[3] = 8'h5A;
        dump("held_img");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
